// File: rtl/clock_select_ctrl_m_if.sv
// CPU access/speed-request and clock-switch status/control signals for clock_select_ctrl_m.
// The slave modport is the controller's view; the master modport is the CPU decoder plus switch side.
interface clock_select_ctrl_m_if;
  logic       access_valid_ip;
  logic       access_slow_ip;
  logic       force_slow_ip;
  logic       selected_hs_ip;
  logic       selected_ls_ip;
  logic       select_hs_op;
  logic       hold_op;
  logic [1:0] state_op;
  logic       timeout_op;

  modport slave (
    input  access_valid_ip,
    input  access_slow_ip,
    input  force_slow_ip,
    input  selected_hs_ip,
    input  selected_ls_ip,
    output select_hs_op,
    output hold_op,
    output state_op,
    output timeout_op
  );

  modport master (
    output access_valid_ip,
    output access_slow_ip,
    output force_slow_ip,
    output selected_hs_ip,
    output selected_ls_ip,
    input  select_hs_op,
    input  hold_op,
    input  state_op,
    input  timeout_op
  );
endinterface

// File: rtl/clock_select_ctrl_m.sv
// Fast-domain controller choosing high/low-speed CPU clock: drives the glitch-free switch select,
// stalls the CPU across each switchover and lingers in slow mode to avoid thrashing.
module clock_select_ctrl_m #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned LINGER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                  ck_ip,
  input logic                  rst_ip,
  clock_select_ctrl_m_if.slave bus
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_FAST    = 2'd0,
    ST_GO_SLOW = 2'd1,
    ST_SLOW    = 2'd2,
    ST_GO_FAST = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] hs_sync;
  logic [SYNC_STAGES-1:0] ls_sync;
  logic                   hs_s;
  logic                   ls_s;
  logic                   slow_req;
  logic                   hs_done;
  logic                   ls_done;
  logic                   in_handshake;

  state_t                 state;
  logic [CNT_W-1:0]       linger_cnt;
  logic [CNT_W-1:0]       tmo_cnt;
  logic                   pending_slow;
  logic                   select_hs;
  logic                   hold;
  logic                   timeout;

  // Switch status is asynchronous to ck_ip; only the synchronised copies are used.
  always_ff @(posedge ck_ip) begin
    if (rst_ip) begin
      hs_sync <= '0;
      ls_sync <= '0;
    end else begin
      hs_sync <= {hs_sync[SYNC_STAGES-2:0], bus.selected_hs_ip};
      ls_sync <= {ls_sync[SYNC_STAGES-2:0], bus.selected_ls_ip};
    end
  end

  assign hs_s         = hs_sync[SYNC_STAGES-1];
  assign ls_s         = ls_sync[SYNC_STAGES-1];
  assign slow_req     = (bus.access_valid_ip & bus.access_slow_ip) | bus.force_slow_ip;
  // A handshake is complete only when exactly one status bit is asserted.
  assign hs_done      = hs_s & ~ls_s;
  assign ls_done      = ls_s & ~hs_s;
  assign in_handshake = (state == ST_GO_SLOW) || (state == ST_GO_FAST);

  // Controller FSM; select/hold are registered decodes of the current state (one cycle behind it).
  always_ff @(posedge ck_ip) begin
    if (rst_ip) begin
      state        <= ST_SLOW;
      linger_cnt   <= CNT_W'(LINGER_CYCLES);
      tmo_cnt      <= '0;
      pending_slow <= 1'b0;
      select_hs    <= 1'b0;
      hold         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      select_hs <= (state == ST_FAST) || (state == ST_GO_FAST);
      hold      <= in_handshake;

      // Saturating handshake timer; entry into a handshake state clears it below.
      if (in_handshake) begin
        if (tmo_cnt != '1) begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
        if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout <= 1'b1;
        end
      end

      case (state)
        ST_FAST: begin
          if (slow_req) begin
            state   <= ST_GO_SLOW;
            tmo_cnt <= '0;
          end
        end

        ST_GO_SLOW: begin
          if (ls_done) begin
            state      <= ST_SLOW;
            linger_cnt <= CNT_W'(LINGER_CYCLES);
          end
        end

        ST_SLOW: begin
          if (slow_req) begin
            linger_cnt <= CNT_W'(LINGER_CYCLES);
          end else begin
            if (linger_cnt != '0) begin
              linger_cnt <= linger_cnt - CNT_W'(1);
            end
            // Leave on the edge where the count reaches zero.
            if (linger_cnt <= CNT_W'(1)) begin
              state   <= ST_GO_FAST;
              tmo_cnt <= '0;
            end
          end
        end

        ST_GO_FAST: begin
          if (hs_done) begin
            pending_slow <= 1'b0;
            if (pending_slow || slow_req) begin
              state   <= ST_GO_SLOW;
              tmo_cnt <= '0;
            end else begin
              state <= ST_FAST;
            end
          end else if (slow_req) begin
            pending_slow <= 1'b1;
          end
        end

        default: state <= ST_SLOW;
      endcase
    end
  end

  assign bus.select_hs_op = select_hs;
  assign bus.hold_op      = hold;
  assign bus.state_op     = state;
  assign bus.timeout_op   = timeout;

endmodule

// File: tb/tb_clock_select_ctrl_m.sv
// Directed bench for clock_select_ctrl_m with a model switch that follows select after 3 cycles.
module tb_clock_select_ctrl_m;

  logic ck = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [2:0] sw_pipe;
  logic       sw_freeze = 1'b0;
  logic       sw_hs;
  logic       sw_ls;

  always #5 ck = ~ck;

  clock_select_ctrl_m_if bus ();

  clock_select_ctrl_m #(
    .SYNC_STAGES   (2),
    .LINGER_CYCLES (8),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .ck_ip (ck),
    .rst_ip(rst),
    .bus   (bus)
  );

  // Model switch: status follows select three cycles later; freeze emulates a dead switch.
  always @(negedge ck) begin
    if (rst) sw_pipe = 3'b000;
    else if (!sw_freeze) sw_pipe = {sw_pipe[1:0], bus.select_hs_op};
    if (rst || !sw_freeze) begin
      sw_hs = sw_pipe[2];
      sw_ls = ~sw_pipe[2];
    end
  end

  assign bus.selected_hs_ip = sw_hs;
  assign bus.selected_ls_ip = sw_ls;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic strobe_slow();
    bus.access_valid_ip = 1'b1;
    bus.access_slow_ip  = 1'b1;
    tick();
    bus.access_valid_ip = 1'b0;
    bus.access_slow_ip  = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.state_op == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.access_valid_ip = 1'b0;
    bus.access_slow_ip  = 1'b0;
    bus.force_slow_ip   = 1'b0;
    repeat (3) tick();
    checks++; if (bus.state_op !== 2'd2) begin failures++; $display("FAIL reset_state: got %0d want 2", bus.state_op); end
    checks++; if (bus.select_hs_op !== 1'b0) begin failures++; $display("FAIL reset_select: got %b want 0", bus.select_hs_op); end
    checks++; if (bus.hold_op !== 1'b0) begin failures++; $display("FAIL reset_hold: got %b want 0", bus.hold_op); end
    checks++; if (bus.timeout_op !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", bus.timeout_op); end
    rst = 1'b0;
    repeat (7) tick();
    checks++; if (bus.state_op !== 2'd2) begin failures++; $display("FAIL boot_linger7: state %0d want 2", bus.state_op); end
    tick();
    checks++; if (bus.state_op !== 2'd3 || bus.hold_op !== 1'b0) begin failures++; $display("FAIL boot_go_fast: state %0d hold %b want 3/0", bus.state_op, bus.hold_op); end
    tick();
    checks++; if (bus.select_hs_op !== 1'b1 || bus.hold_op !== 1'b1) begin failures++; $display("FAIL boot_sel_hold: sel %b hold %b want 1/1", bus.select_hs_op, bus.hold_op); end
    repeat (4) tick();
    checks++; if (bus.state_op !== 2'd3) begin failures++; $display("FAIL boot_wait_hs: state %0d want 3", bus.state_op); end
    tick();
    checks++; if (bus.state_op !== 2'd0 || bus.hold_op !== 1'b1) begin failures++; $display("FAIL boot_fast: state %0d hold %b want 0/1", bus.state_op, bus.hold_op); end
    tick();
    checks++; if (bus.hold_op !== 1'b0 || bus.select_hs_op !== 1'b1) begin failures++; $display("FAIL boot_release: hold %b sel %b want 0/1", bus.hold_op, bus.select_hs_op); end
  endtask

  task automatic test_fast_access();
    bus.access_valid_ip = 1'b1;
    bus.access_slow_ip  = 1'b0;
    tick();
    bus.access_valid_ip = 1'b0;
    bus.access_slow_ip  = 1'b1;
    tick();
    bus.access_slow_ip  = 1'b0;
    tick();
    checks++; if (bus.state_op !== 2'd0 || bus.select_hs_op !== 1'b1 || bus.hold_op !== 1'b0) begin
      failures++; $display("FAIL fast_access: state %0d sel %b hold %b want 0/1/0", bus.state_op, bus.select_hs_op, bus.hold_op);
    end
  endtask

  task automatic test_slow_strobe();
    bit ok;
    strobe_slow();
    checks++; if (bus.state_op !== 2'd1 || bus.select_hs_op !== 1'b1) begin failures++; $display("FAIL strobe_go_slow: state %0d sel %b want 1/1", bus.state_op, bus.select_hs_op); end
    tick();
    checks++; if (bus.select_hs_op !== 1'b0 || bus.hold_op !== 1'b1) begin failures++; $display("FAIL strobe_latency: sel %b hold %b want 0/1", bus.select_hs_op, bus.hold_op); end
    repeat (4) tick();
    checks++; if (bus.state_op !== 2'd1 || bus.hold_op !== 1'b1) begin failures++; $display("FAIL strobe_wait_ls: state %0d hold %b want 1/1", bus.state_op, bus.hold_op); end
    tick();
    checks++; if (bus.state_op !== 2'd2) begin failures++; $display("FAIL strobe_slow_entry: state %0d want 2", bus.state_op); end
    tick();
    checks++; if (bus.hold_op !== 1'b0 || bus.select_hs_op !== 1'b0) begin failures++; $display("FAIL strobe_release: hold %b sel %b want 0/0", bus.hold_op, bus.select_hs_op); end
    repeat (6) tick();
    checks++; if (bus.state_op !== 2'd2) begin failures++; $display("FAIL strobe_linger: state %0d want 2", bus.state_op); end
    tick();
    checks++; if (bus.state_op !== 2'd3) begin failures++; $display("FAIL strobe_linger_exit: state %0d want 3", bus.state_op); end
    wait_state(2'd0, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL strobe_return_fast: state %0d want 0 within 20 cycles", bus.state_op); end
    tick();
  endtask

  task automatic test_linger_and_pending();
    bit ok;
    strobe_slow();
    wait_state(2'd2, 30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL linger_enter_slow: state %0d want 2 within 30 cycles", bus.state_op); end
    for (int i = 0; i < 4; i++) begin
      strobe_slow();
      repeat (4) begin
        tick();
        checks++; if (bus.state_op !== 2'd2 || bus.select_hs_op !== 1'b0) begin failures++; $display("FAIL linger_hold_slow: state %0d sel %b want 2/0", bus.state_op, bus.select_hs_op); end
      end
    end
    // Final strobe lands on the edge the counter would reach zero; the reload must win.
    repeat (3) tick();
    strobe_slow();
    checks++; if (bus.state_op !== 2'd2) begin failures++; $display("FAIL linger_reload_wins: state %0d want 2", bus.state_op); end
    repeat (7) tick();
    checks++; if (bus.state_op !== 2'd2 || bus.select_hs_op !== 1'b0) begin failures++; $display("FAIL linger_n7: state %0d sel %b want 2/0", bus.state_op, bus.select_hs_op); end
    tick();
    checks++; if (bus.state_op !== 2'd3 || bus.select_hs_op !== 1'b0) begin failures++; $display("FAIL linger_n8: state %0d sel %b want 3/0", bus.state_op, bus.select_hs_op); end
    tick();
    checks++; if (bus.select_hs_op !== 1'b1) begin failures++; $display("FAIL linger_n9_sel: got %b want 1", bus.select_hs_op); end
    // Now one edge into GO_FAST; a slow request here must wait for the hs handshake.
    strobe_slow();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.state_op !== 2'd3 || bus.select_hs_op !== 1'b1 || bus.hold_op !== 1'b1) begin
        failures++; $display("FAIL pending_in_go_fast: state %0d sel %b hold %b want 3/1/1", bus.state_op, bus.select_hs_op, bus.hold_op);
      end
      tick();
    end
    checks++; if (bus.state_op !== 2'd3 || bus.select_hs_op !== 1'b1) begin failures++; $display("FAIL pending_e5: state %0d sel %b want 3/1", bus.state_op, bus.select_hs_op); end
    tick();
    checks++; if (bus.state_op !== 2'd1 || bus.hold_op !== 1'b1) begin failures++; $display("FAIL pending_to_go_slow: state %0d hold %b want 1/1", bus.state_op, bus.hold_op); end
    tick();
    checks++; if (bus.select_hs_op !== 1'b0 || bus.hold_op !== 1'b1) begin failures++; $display("FAIL pending_sel_drop: sel %b hold %b want 0/1", bus.select_hs_op, bus.hold_op); end
    repeat (4) begin
      tick();
      checks++; if (bus.hold_op !== 1'b1 || bus.state_op !== 2'd1) begin failures++; $display("FAIL pending_hold_kept: hold %b state %0d want 1/1", bus.hold_op, bus.state_op); end
    end
    tick();
    checks++; if (bus.state_op !== 2'd2 || bus.hold_op !== 1'b1) begin failures++; $display("FAIL pending_slow_entry: state %0d hold %b want 2/1", bus.state_op, bus.hold_op); end
    tick();
    checks++; if (bus.hold_op !== 1'b0) begin failures++; $display("FAIL pending_release: hold %b want 0", bus.hold_op); end
  endtask

  task automatic test_timeout();
    bit ok;
    wait_state(2'd0, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout_reach_fast: state %0d want 0 within 40 cycles", bus.state_op); end
    tick();
    sw_freeze = 1'b1;
    strobe_slow();
    checks++; if (bus.state_op !== 2'd1) begin failures++; $display("FAIL timeout_go_slow: state %0d want 1", bus.state_op); end
    repeat (254) tick();
    checks++; if (bus.timeout_op !== 1'b0) begin failures++; $display("FAIL timeout_early: got %b want 0 at cycle 254", bus.timeout_op); end
    tick();
    checks++; if (bus.timeout_op !== 1'b1 || bus.state_op !== 2'd1) begin failures++; $display("FAIL timeout_set: timeout %b state %0d want 1/1", bus.timeout_op, bus.state_op); end
    repeat (10) tick();
    checks++; if (bus.timeout_op !== 1'b1 || bus.state_op !== 2'd1 || bus.hold_op !== 1'b1) begin
      failures++; $display("FAIL timeout_sticky: timeout %b state %0d hold %b want 1/1/1", bus.timeout_op, bus.state_op, bus.hold_op);
    end
    rst = 1'b1;
    tick();
    checks++; if (bus.state_op !== 2'd2 || bus.select_hs_op !== 1'b0 || bus.hold_op !== 1'b0 || bus.timeout_op !== 1'b0) begin
      failures++; $display("FAIL timeout_reset: state %0d sel %b hold %b timeout %b want 2/0/0/0", bus.state_op, bus.select_hs_op, bus.hold_op, bus.timeout_op);
    end
    rst = 1'b0;
    sw_freeze = 1'b0;
  endtask

  task automatic test_force_slow();
    bit ok;
    bit left_slow;
    wait_state(2'd0, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL force_reach_fast: state %0d want 0 within 40 cycles", bus.state_op); end
    tick();
    bus.force_slow_ip = 1'b1;
    tick();
    checks++; if (bus.state_op !== 2'd1) begin failures++; $display("FAIL force_go_slow: state %0d want 1", bus.state_op); end
    left_slow = 1'b0;
    ok = 1'b0;
    for (int i = 1; i < 100; i++) begin
      tick();
      if (bus.state_op == 2'd2) ok = 1'b1;
      else if (ok) left_slow = 1'b1;
    end
    checks++; if (!ok || left_slow) begin failures++; $display("FAIL force_stays_slow: reached %b left %b want 1/0", ok, left_slow); end
    checks++; if (bus.select_hs_op !== 1'b0 || bus.hold_op !== 1'b0) begin failures++; $display("FAIL force_outputs: sel %b hold %b want 0/0", bus.select_hs_op, bus.hold_op); end
    bus.force_slow_ip = 1'b0;
    repeat (7) tick();
    checks++; if (bus.state_op !== 2'd2) begin failures++; $display("FAIL force_release_r7: state %0d want 2", bus.state_op); end
    tick();
    checks++; if (bus.state_op !== 2'd3) begin failures++; $display("FAIL force_release_r8: state %0d want 3", bus.state_op); end
    tick();
    checks++; if (bus.select_hs_op !== 1'b1) begin failures++; $display("FAIL force_release_sel: got %b want 1", bus.select_hs_op); end
    repeat (4) tick();
    checks++; if (bus.state_op !== 2'd3) begin failures++; $display("FAIL force_release_r13: state %0d want 3", bus.state_op); end
    tick();
    checks++; if (bus.state_op !== 2'd0) begin failures++; $display("FAIL force_release_fast: state %0d want 0", bus.state_op); end
    tick();
    checks++; if (bus.hold_op !== 1'b0) begin failures++; $display("FAIL force_release_hold: got %b want 0", bus.hold_op); end
  endtask

  initial begin
    test_reset();
    test_fast_access();
    test_slow_strobe();
    test_linger_and_pending();
    test_timeout();
    test_force_slow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_select_ctrl_m.md
# clock_select_ctrl_m

Fast-domain controller that decides when the CPU runs from the high-speed or the low-speed clock, and drives the select input of the downstream glitch-free clock switch. It decodes per-access speed requests, holds the CPU during each switchover and applies a linger period before returning to high speed, which prevents thrashing. It waits on the switch's `selected_hs`/`selected_ls` status, which is synchronised locally, before releasing the CPU.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops in each status synchroniser, minimum 2.
- `LINGER_CYCLES`, default 8: ck_ip cycles spent in SLOW with no slow demand before returning to fast. Range 1..255.
- `TIMEOUT_CYCLES`, default 255: handshake cycles before `timeout_op` sets. Range 1..255.

Ports:
- `ck_ip` in 1: free-running high-speed oscillator, not the switched clock. One clock only; all logic on its rising edge.
- `rst_ip` in 1: synchronous, active-high reset.
- `access_valid_ip` in 1: one-cycle strobe, a new CPU access has been decoded.
- `access_slow_ip` in 1: access targets the slow region. Qualified by `access_valid_ip`.
- `force_slow_ip` in 1: level input that pins operation to low speed.
- `selected_hs_ip` in 1: switch status. Asynchronous.
- `selected_ls_ip` in 1: switch status. Asynchronous.
- `select_hs_op` out 1: registered select to the clock switch.
- `hold_op` out 1: registered CPU stall (RDY low) while a switchover is in progress.
- `state_op` out 2: current FSM state, for debug.
- `timeout_op` out 1: sticky handshake-timeout flag.

## Operation
- `selected_hs_ip` and `selected_ls_ip` each pass through a `SYNC_STAGES` flop chain, giving `hs_s` and `ls_s`. No logic reads the raw inputs.
- `slow_req` = (`access_valid_ip` & `access_slow_ip`) | `force_slow_ip`.
- FSM states and encodings: FAST=0, GO_SLOW=1, SLOW=2, GO_FAST=3.
- FAST:
  - Outputs: `select_hs_op`=1, `hold_op`=0.
  - `slow_req` → GO_SLOW.
- GO_SLOW:
  - Outputs: `select_hs_op`=0, `hold_op`=1.
  - `ls_s`=1 & `hs_s`=0 → SLOW; linger counter loads `LINGER_CYCLES`.
- SLOW:
  - Outputs: `select_hs_op`=0, `hold_op`=0.
  - `slow_req` reloads the linger counter to `LINGER_CYCLES`.
  - Otherwise the counter decrements by 1 and saturates at 0.
  - Counter==0 with no `slow_req` → GO_FAST.
  - Fast-region accesses execute at low speed with no stall.
- GO_FAST:
  - Outputs: `select_hs_op`=1, `hold_op`=1.
  - `slow_req` sets a `pending_slow` flag; `select_hs_op` never changes mid-handshake.
  - `hs_s`=1 & `ls_s`=0 → FAST if `pending_slow`=0, else → GO_SLOW with `hold_op` staying 1. `pending_slow` clears on exit.
- Timeout counter:
  - Clears on entry to GO_SLOW or GO_FAST and increments in those states. It saturates.
  - Reaching `TIMEOUT_CYCLES` sets `timeout_op`. `timeout_op` clears only on reset.
  - A timeout does not change FSM behaviour; the FSM keeps waiting.
- Reset values: state=SLOW (matches the switch's reset, which selects the low-speed clock), `select_hs_op`=0, `hold_op`=0, linger counter=`LINGER_CYCLES`, timeout counter=0, `timeout_op`=0, `pending_slow`=0, synchroniser flops=0. Reset mid-handshake aborts it and returns to these values.

## Timing
- All outputs are registered. `select_hs_op` and `hold_op` change in the cycle after the state transition that causes them.
- FAST→GO_SLOW: with `slow_req` at edge N, `select_hs_op`=0 and `hold_op`=1 are visible after edge N+1 (1-cycle latency).
- Handshake completion: status change at the switch → `hs_s`/`ls_s` valid after `SYNC_STAGES` edges → state change after 1 more edge → `hold_op` falls after 1 more edge.
- Linger: with the last `slow_req` at edge N, the earliest `select_hs_op`=1 is after edge N+`LINGER_CYCLES`+1.
- Simultaneous `slow_req` and linger counter reaching 0: the reload wins, and the FSM stays in SLOW.
- Both `hs_s`/`ls_s` at 1, or both at 0: treated as incomplete; the FSM keeps waiting.

## Test plan
- Reset, then a model switch that follows select after 3 cycles: after reset `state_op`=2 and `select_hs_op`=0. With no requests, GO_FAST is entered after 8 cycles, then FAST; `hold_op` is high only during GO_FAST.
- In FAST, one slow strobe → next cycle `select_hs_op`=0 and `hold_op`=1. `hold_op` drops 2+1+1 cycles after the model reports `ls`. 8 idle cycles later the FSM returns to FAST.
- Slow strobes every 5 cycles while in SLOW → no exit. `select_hs_op` stays 0 until 8 cycles after the final strobe.
- Slow strobe during GO_FAST → `select_hs_op` stays 1 until `hs_s`. The FSM then goes directly to GO_SLOW and `hold_op` never deasserts between the two handshakes.
- Model switch never acknowledges, `TIMEOUT_CYCLES`=255 → `timeout_op` rises at handshake cycle 255 and stays 1. The FSM stays in GO_SLOW; `rst_ip` pulse clears everything.
- `force_slow_ip` held high for 100 cycles in FAST → GO_SLOW then SLOW with no return. After release, FAST is re-entered after 8 cycles plus handshake latency.
